// File: rtl/fpmul_issuer.sv
// Issues IEEE-754 operand pairs from a FWFT FIFO to an external multiplier one at a time,
// collecting product/flag results (or timeout markers) into a FWFT result FIFO in issue order.
module fpmul_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [31:0] mul_p,
  input  logic        mul_of,
  input  logic        mul_uf,
  input  logic        mul_nanf,
  input  logic        mul_inff,
  input  logic        mul_dnf,
  input  logic        mul_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic [6:0]  out_flags,
  output logic        busy,
  output logic        stray_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, GAP} state_t;

  state_t        state;
  logic          init_cnt;
  logic [7:0]    wait_cnt;
  logic          ready_en;

  logic [63:0]   opq_mem [DEPTH];
  logic [AW-1:0] opq_wr;
  logic [AW-1:0] opq_rd;
  logic [AW:0]   opq_count;
  logic          opq_push;
  logic          opq_pop;

  logic [38:0]   res_mem [DEPTH];
  logic [AW-1:0] res_wr;
  logic [AW-1:0] res_rd;
  logic [AW:0]   res_count;
  logic          res_push;
  logic          res_pop;
  logic          res_wr_en;
  logic [38:0]   res_data;

  logic          issue_go;

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_en && (opq_count != FULL);
  assign opq_push  = in_valid && in_ready;
  assign issue_go  = (state == IDLE) && (opq_count != '0) && (res_count != FULL);
  assign opq_pop   = issue_go;

  assign out_valid = (res_count != '0);
  assign res_pop   = out_valid && out_ready;
  assign res_push  = (state == WAIT) && (mul_done || (wait_cnt == TO_LAST));
  assign res_wr_en = res_push && ((res_count != FULL) || res_pop);
  assign res_data  = mul_done ? {1'b0, mul_of, mul_uf, mul_nanf, mul_inff, mul_dnf, mul_zf, mul_p}
                              : {7'b1000000, 32'h0000_0000};

  assign out_p     = out_valid ? res_mem[res_rd][31:0]  : 32'h0000_0000;
  assign out_flags = out_valid ? res_mem[res_rd][38:32] : 7'b0000000;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (opq_push) opq_mem[opq_wr] <= {in_a, in_b};
    if (res_wr_en) res_mem[res_wr] <= res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opq_wr    <= '0;
      opq_rd    <= '0;
      opq_count <= '0;
    end else begin
      if (opq_push) opq_wr <= opq_wr + 1'b1;
      if (opq_pop)  opq_rd <= opq_rd + 1'b1;
      case ({opq_push, opq_pop})
        2'b10:   opq_count <= opq_count + 1'b1;
        2'b01:   opq_count <= opq_count - 1'b1;
        default: opq_count <= opq_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
    end else begin
      if (res_wr_en) res_wr <= res_wr + 1'b1;
      if (res_pop)   res_rd <= res_rd + 1'b1;
      case ({res_wr_en, res_pop})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_cnt   <= 1'b0;
      wait_cnt   <= 8'd0;
      ready_en   <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= 32'h0000_0000;
      mul_b      <= 32'h0000_0000;
      stray_done <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      mul_start <= 1'b0;
      if (mul_done && (state != WAIT)) stray_done <= 1'b1;
      case (state)
        INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) state <= IDLE;
        end
        IDLE: begin
          if (issue_go) begin
            state          <= ISSUE;
            mul_start      <= 1'b1;
            {mul_a, mul_b} <= opq_mem[opq_rd];
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= 8'd0;
        end
        WAIT: begin
          if (res_push) state <= GAP;
          else          wait_cnt <= wait_cnt + 8'd1;
        end
        GAP:     state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_issuer.sv
// Scoreboard bench for fpmul_issuer: behavioural multiplier model, expected results queued
// at operand push and compared in order as the result FIFO drains.
module tb_fpmul_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic        in_ready;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic        mul_done = 1'b0;
  logic [31:0] mul_p = 32'h0;
  logic        mul_of = 1'b0;
  logic        mul_uf = 1'b0;
  logic        mul_nanf = 1'b0;
  logic        mul_inff = 1'b0;
  logic        mul_dnf = 1'b0;
  logic        mul_zf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic [6:0]  out_flags;
  logic        busy;
  logic        stray_done;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int model_lat = 9;
  bit model_en = 1'b1;
  int stray_req = 0;
  logic [38:0] exp_q[$];

  fpmul_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_p(mul_p),
    .mul_of(mul_of), .mul_uf(mul_uf), .mul_nanf(mul_nanf),
    .mul_inff(mul_inff), .mul_dnf(mul_dnf), .mul_zf(mul_zf),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
    .busy(busy), .stray_done(stray_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start === 1'b1) start_cnt <= start_cnt + 1;
    if (mul_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Stand-in multiplier: {flags6, product}; two fixed real cases, otherwise a traceable pattern
  function automatic logic [37:0] model_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return {6'b000000, 32'h4040_0000};
    if (a == 32'h7FC0_0000) return {6'b001000, 32'h7FC0_0000};
    return {a[5:0], a ^ b};
  endfunction

  // All-ones can never be a real result (TO set with nonzero product)
  function automatic logic [38:0] next_exp();
    if (exp_q.size() == 0) return {39{1'b1}};
    return exp_q.pop_front();
  endfunction

  initial begin : mult_model
    logic [37:0] r;
    int stray_seen;
    stray_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        mul_p = 32'hDEAD_BEEF;
        {mul_of, mul_uf, mul_nanf, mul_inff, mul_dnf, mul_zf} = 6'b111111;
        mul_done = 1'b1;
        @(posedge clk); #1;
        mul_done = 1'b0; mul_p = 32'h0;
        {mul_of, mul_uf, mul_nanf, mul_inff, mul_dnf, mul_zf} = 6'b000000;
      end else if (mul_start === 1'b1 && model_en) begin
        r = model_fn(mul_a, mul_b);
        repeat (model_lat) @(posedge clk);
        #1;
        mul_p = r[31:0];
        {mul_of, mul_uf, mul_nanf, mul_inff, mul_dnf, mul_zf} = r[37:32];
        mul_done = 1'b1;
        @(posedge clk); #1;
        mul_done = 1'b0; mul_p = 32'h0;
        {mul_of, mul_uf, mul_nanf, mul_inff, mul_dnf, mul_zf} = 6'b000000;
      end
    end
  end

  // kind: 0 = normal result expected, 1 = timeout result expected, 2 = no result expected
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input int kind);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL push_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (kind == 0) exp_q.push_back({1'b0, model_fn(a, b)});
    else if (kind == 1) exp_q.push_back({7'b1000000, 32'h0});
  endtask

  task automatic measure_latency(output int lat);
    int n;
    n = 0; lat = -1;
    while (mul_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (mul_start !== 1'b1) return;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (out_valid === 1'b1) lat = n;
  endtask

  task automatic test_reset();
    int n; int got; bit started; bit acc; logic [38:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if ({in_ready, out_valid} !== 2'b00) begin fails++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid); end
    tests++; if ({out_flags, out_p} !== 39'd0) begin fails++;
      $display("FAIL reset_out: flags=%b p=%h, required 0", out_flags, out_p); end
    tests++; if (busy !== 1'b1) begin fails++;
      $display("FAIL reset_busy: busy=%b, required 1", busy); end
    tests++; if ({mul_start, stray_done} !== 2'b00) begin fails++;
      $display("FAIL reset_ctrl: mul_start=%b stray_done=%b, required 0 0", mul_start, stray_done); end
    tests++; if ({mul_a, mul_b} !== 64'd0) begin fails++;
      $display("FAIL reset_operands: mul_a=%h mul_b=%h, required 0", mul_a, mul_b); end
    rst_n = 1'b1;
    in_a = 32'h1234_5678; in_b = 32'h0000_0003; in_valid = 1'b1;
    exp_q.push_back({1'b0, model_fn(in_a, in_b)});
    n = 0; started = 1'b0;
    while (!started && n < 20) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1; n++;
      if (acc) in_valid = 1'b0;
      if (n == 1) begin
        tests++; if (in_ready !== 1'b1) begin fails++;
          $display("FAIL in_ready_rise: in_ready=%b one cycle after release, required 1", in_ready); end
      end
      if (mul_start === 1'b1) started = 1'b1;
    end
    tests++; if (!started || n != 3) begin fails++;
      $display("FAIL first_start: started=%b after %0d cycles, required start at cycle 3", started, n); end
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 1 && n < 100) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e) begin fails++;
          $display("FAIL reset_first_result: flags=%b p=%h, required flags=%b p=%h", out_flags, out_p, e[38:32], e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    if (got < 1) begin tests++; fails++; $display("FAIL reset_first_result: got 0 results, required 1"); end
  endtask

  task automatic test_single_op();
    int lat; int n; int got; logic [38:0] e;
    model_lat = 9;
    push_op(32'h3FC0_0000, 32'h4000_0000, 0);
    measure_latency(lat);
    tests++; if (lat != 10) begin fails++;
      $display("FAIL single_latency: start-to-out_valid=%0d cycles, required 10", lat); end
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 1 && n < 50) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e || out_p !== 32'h4040_0000) begin fails++;
          $display("FAIL single_result: flags=%b p=%h, required flags=%b p=%h", out_flags, out_p, e[38:32], e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    tests++; if (got != 1 || out_valid !== 1'b0) begin fails++;
      $display("FAIL single_count: results=%0d out_valid=%b, required 1 result then empty", got, out_valid); end
  endtask

  task automatic test_timeout();
    int lat; int n; int got; logic [38:0] e;
    model_en = 1'b0;
    push_op(32'hAAAA_0001, 32'h3F80_0000, 1);
    measure_latency(lat);
    tests++; if (lat != TIMEOUT + 1) begin fails++;
      $display("FAIL timeout_latency: start-to-out_valid=%0d cycles, required %0d", lat, TIMEOUT + 1); end
    model_en = 1'b1; model_lat = 4;
    push_op(32'h2000_0007, 32'h0101_0101, 0);
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 2 && n < 100) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e) begin fails++;
          $display("FAIL timeout_result%0d: flags=%b p=%h, required flags=%b p=%h", got, out_flags, out_p, e[38:32], e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    if (got < 2) begin tests++; fails++; $display("FAIL timeout_count: got %0d results, required 2", got); end
  endtask

  task automatic test_nan();
    int n; int got; logic [38:0] e;
    model_lat = 2;
    push_op(32'h7FC0_0000, 32'h3F80_0000, 0);
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 1 && n < 50) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e || out_flags !== 7'b0001000) begin fails++;
          $display("FAIL nan_flags: flags=%b p=%h, required flags=0001000 p=%h", out_flags, out_p, e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    if (got < 1) begin tests++; fails++; $display("FAIL nan_count: got 0 results, required 1"); end
  endtask

  task automatic test_backpressure();
    int base; int n; int got; logic [38:0] e;
    model_lat = 3; out_ready = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 8; i++) push_op(32'h1000_0000 + 32'(i), 32'h0F0F_0000 + 32'(i * 3), 0);
    repeat (40) @(posedge clk);
    #1;
    tests++; if (start_cnt - base != 4) begin fails++;
      $display("FAIL bp_starts: %0d mul_start pulses, required 4", start_cnt - base); end
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid); end
    got = 0; n = 0;
    fork
      begin
        push_op(32'h1000_0008, 32'h0F0F_0018, 0);
        push_op(32'h1000_0009, 32'h0F0F_001B, 0);
      end
      begin
        out_ready = 1'b1;
        while (got < 10 && n < 400) begin
          if (out_valid === 1'b1) begin
            e = next_exp(); tests++; got++;
            if ({out_flags, out_p} !== e) begin fails++;
              $display("FAIL bp_order%0d: flags=%b p=%h, required flags=%b p=%h", got, out_flags, out_p, e[38:32], e[31:0]); end
          end
          @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
      end
    join
    tests++; if (got != 10 || start_cnt - base != 10 || out_valid !== 1'b0) begin fails++;
      $display("FAIL bp_drain: results=%0d starts=%0d out_valid=%b, required 10 10 0", got, start_cnt - base, out_valid); end
    tests++; if (stray_done !== 1'b0) begin fails++;
      $display("FAIL no_stray: stray_done=%b after in-WAIT completions, required 0", stray_done); end
  endtask

  task automatic test_simultaneous();
    int base; int n; int got; logic [38:0] e;
    model_lat = 6; out_ready = 1'b0;
    base = done_cnt;
    for (int i = 0; i < 4; i++) push_op(32'h3000_0010 + 32'(i), 32'h00FF_00FF, 0);
    n = 0;
    while (!(mul_done === 1'b1 && done_cnt == base + 3) && n < 300) begin @(posedge clk); #1; n++; end
    tests++; if (mul_done !== 1'b1 || out_valid !== 1'b1) begin fails++;
      $display("FAIL simul_setup: mul_done=%b out_valid=%b at fourth completion, required 1 1", mul_done, out_valid); end
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 4 && n < 100) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e) begin fails++;
          $display("FAIL simul_order%0d: flags=%b p=%h, required flags=%b p=%h", got, out_flags, out_p, e[38:32], e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    tests++; if (got != 4 || out_valid !== 1'b0) begin fails++;
      $display("FAIL simul_count: results=%0d out_valid=%b, required 4 then empty", got, out_valid); end
  endtask

  task automatic test_reset_mid();
    int n; int got; logic [38:0] e;
    model_en = 1'b0;
    push_op(32'h5555_0000, 32'h3F80_0000, 2);
    n = 0;
    while (mul_start !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++;
      $display("FAIL mid_busy: busy=%b while waiting, required 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if ({busy, out_valid, in_ready} !== 3'b100) begin fails++;
      $display("FAIL mid_async: busy/out_valid/in_ready=%b, required 100", {busy, out_valid, in_ready}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_en = 1'b1;
    tests++; if (stray_done !== 1'b0) begin fails++;
      $display("FAIL mid_stray_clear: stray_done=%b after reset, required 0", stray_done); end
    stray_req++;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (stray_done !== 1'b1 || out_valid !== 1'b0) begin fails++;
      $display("FAIL mid_stray: stray_done=%b out_valid=%b, required 1 0", stray_done, out_valid); end
    model_lat = 5;
    push_op(32'h4000_0021, 32'h0000_1111, 0);
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 1 && n < 60) begin
      if (out_valid === 1'b1) begin
        e = next_exp(); tests++; got++;
        if ({out_flags, out_p} !== e) begin fails++;
          $display("FAIL mid_next_op: flags=%b p=%h, required flags=%b p=%h", out_flags, out_p, e[38:32], e[31:0]); end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    tests++; if (got != 1 || out_valid !== 1'b0 || exp_q.size() != 0) begin fails++;
      $display("FAIL mid_count: results=%0d out_valid=%b pending=%0d, required 1 0 0", got, out_valid, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_timeout();
    test_nan();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
